// File: rtl/cgra_pkg.sv
// -----------------------------------------------------------------------------
// cgra_pkg
// Shared CGRA constants (column count, kernel-ID / kernel-memory widths, PC
// width), the bounds of the start-PC field inside a kernel configuration word,
// and the accelerator-launcher FSM state encoding.
// -----------------------------------------------------------------------------
package cgra_pkg;

  localparam int N_COL    = 4;
  localparam int KER_ID_W = 4;
  localparam int KMEM_W   = 32;
  localparam int PC_W     = 5;

  // Start-PC field of a kernel configuration word.
  localparam int KER_PC_LB = 0;
  localparam int KER_PC_HB = KER_PC_LB + PC_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_LAUNCH = 2'd2
  } launch_state_e;

endpackage

// File: rtl/cgra_acc_launcher_if.sv
// -----------------------------------------------------------------------------
// cgra_acc_launcher_if
// Bundles the launcher's request handshake, kernel-memory read port and
// per-column control/status lines.
//   acc_req / ker_id / acc_ack     : column-mask request, kernel ID, 1-cycle ack
//   kmem_addr / kmem_rdata         : kernel-memory read (data 1 cycle after addr)
//   col_start / col_pc             : per-column start pulse and start PC
//   col_done / col_busy / acc_end  : completion pulses, ownership, group end
// Modports: slave = launcher side, master = requester/array/memory side.
// -----------------------------------------------------------------------------
interface cgra_acc_launcher_if;
  import cgra_pkg::*;

  logic [N_COL-1:0]    acc_req;
  logic [KER_ID_W-1:0] ker_id;
  logic                acc_ack;
  logic [KER_ID_W-1:0] kmem_addr;
  logic [KMEM_W-1:0]   kmem_rdata;
  logic [N_COL-1:0]    col_start;
  logic [PC_W-1:0]     col_pc;
  logic [N_COL-1:0]    col_done;
  logic [N_COL-1:0]    col_busy;
  logic [N_COL-1:0]    acc_end;

  modport slave (
    input  acc_req, ker_id, kmem_rdata, col_done,
    output acc_ack, kmem_addr, col_start, col_pc, col_busy, acc_end
  );

  modport master (
    output acc_req, ker_id, kmem_rdata, col_done,
    input  acc_ack, kmem_addr, col_start, col_pc, col_busy, acc_end
  );

endinterface

// File: rtl/cgra_col_tracker.sv
// -----------------------------------------------------------------------------
// cgra_col_tracker
// Per-column ownership and completion tracking for launched column groups.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   launch_i       : mask of the group being launched this cycle
//   col_done_i     : one-cycle per-column completion pulses
//   busy_o         : registered busy mask
//   acc_end_o      : OR of the masks of all groups completing this cycle
// -----------------------------------------------------------------------------
module cgra_col_tracker
  import cgra_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_COL-1:0] launch_i,
  input  logic [N_COL-1:0] col_done_i,
  output logic [N_COL-1:0] busy_o,
  output logic [N_COL-1:0] acc_end_o
);

  logic [N_COL-1:0] busy_q;
  logic [N_COL-1:0] done_q;
  logic [N_COL-1:0] done_eff;
  logic [N_COL-1:0] acc_end;
  logic [N_COL-1:0] grp_q   [N_COL];  // group mask owning each column
  logic [N_COL-1:0] grp_end [N_COL];  // group mask if that group ends now

  // Done pulses on idle columns are dropped; this cycle's pulses count
  // towards completion immediately.
  assign done_eff = done_q | (col_done_i & busy_q);

  // Every member column of a finishing group reports the same mask, so the
  // OR below yields each group once even though it is seen per column.
  for (genvar gi = 0; gi < N_COL; gi++) begin : g_col
    assign grp_end[gi] = (busy_q[gi] && ((grp_q[gi] & ~done_eff) == '0))
                         ? grp_q[gi] : '0;
  end

  always_comb begin
    acc_end = '0;
    for (int c = 0; c < N_COL; c++) begin
      acc_end = acc_end | grp_end[c];
    end
  end

  // A launch only targets columns that were not busy, so it never overlaps
  // a group that is completing in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      done_q <= '0;
      for (int c = 0; c < N_COL; c++) begin
        grp_q[c] <= '0;
      end
    end else begin
      busy_q <= (busy_q & ~acc_end) | launch_i;
      done_q <= done_eff & ~acc_end;
      for (int c = 0; c < N_COL; c++) begin
        if (launch_i[c]) begin
          grp_q[c] <= launch_i;
        end else if (acc_end[c]) begin
          grp_q[c] <= '0;
        end
      end
    end
  end

  assign busy_o    = busy_q;
  assign acc_end_o = acc_end;

endmodule

// File: rtl/cgra_acc_launcher.sv
// -----------------------------------------------------------------------------
// cgra_acc_launcher
// Responder for accelerator requests: waits for a request whose columns are
// all free, reads the kernel start PC from kernel memory, launches the column
// group, acks the requester and hands the group to the completion tracker.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus_io  : cgra_acc_launcher_if.slave (request, kernel memory, columns)
// Timing: IDLE (request qualifies) -> FETCH (address out, request latched)
//         -> LAUNCH (ack, start pulses, PC from read data) -> IDLE.
// -----------------------------------------------------------------------------
module cgra_acc_launcher
  import cgra_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cgra_acc_launcher_if.slave    bus_io
);

  launch_state_e       state_q, state_d;
  logic [N_COL-1:0]    req_q;
  logic [KER_ID_W-1:0] kmem_addr_q;

  logic [N_COL-1:0]    launch_mask;
  logic [N_COL-1:0]    busy;
  logic [N_COL-1:0]    acc_end;
  logic                acc_ack;
  logic [PC_W-1:0]     col_pc;
  logic [KER_ID_W-1:0] kmem_addr;

  // Only the start-PC field of the configuration word is consumed here.
  logic unused_kmem_bits;
  assign unused_kmem_bits = ^bus_io.kmem_rdata[KMEM_W-1:KER_PC_HB+1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      kmem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) begin
        req_q       <= bus_io.acc_req;
        kmem_addr_q <= bus_io.ker_id;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    launch_mask = '0;
    acc_ack     = 1'b0;
    col_pc      = '0;
    kmem_addr   = kmem_addr_q;  // address holds its last value outside FETCH
    unique case (state_q)
      ST_IDLE: begin
        // Qualified against the registered busy mask: a column freed this
        // cycle is only available from the next cycle on.
        if ((bus_io.acc_req != '0) && ((bus_io.acc_req & busy) == '0)) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        kmem_addr = bus_io.ker_id;
        state_d   = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        acc_ack     = 1'b1;
        launch_mask = req_q;
        col_pc      = bus_io.kmem_rdata[KER_PC_HB:KER_PC_LB];
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cgra_col_tracker u_tracker (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .launch_i   (launch_mask),
    .col_done_i (bus_io.col_done),
    .busy_o     (busy),
    .acc_end_o  (acc_end)
  );

  assign bus_io.acc_ack   = acc_ack;
  assign bus_io.kmem_addr = kmem_addr;
  assign bus_io.col_start = launch_mask;
  assign bus_io.col_pc    = col_pc;
  assign bus_io.col_busy  = busy;
  assign bus_io.acc_end   = acc_end;

endmodule
